// File: rtl/rv32_mem_stage_if.sv
// Data-memory bus between the rv32 memory stage (master) and data memory (slave).
// Word-addressed request/grant with a separate read-data-valid response.
interface rv32_mem_stage_if;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_we, data_be, data_addr, data_wdata,
      input  data_gnt, data_rvalid, data_rdata
   );

   modport slave (
      input  data_req, data_we, data_be, data_addr, data_wdata,
      output data_gnt, data_rvalid, data_rdata
   );
endinterface

// File: rtl/rv32_mem_stage.sv
// rv32 memory stage: issues load/store transactions on the data bus, formats
// load data and registers the writeback buffer; stalls the front end while busy.
`ifndef RV_NOP
`define RV_NOP 32'h0000_0013
`endif

package rv32_mem_pkg;
   typedef enum logic [3:0] {
      MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
   } mem_op_t;

   typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC4} wb_src_t;

   typedef struct packed {
      mem_op_t mem_op;
      wb_src_t wb_result_src;
   } decoded_instr_t;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      decoded_instr_t decoded_instr;
      logic [31:0]    mem_addr;
      logic [31:0]    wb_result;
   } exec_mem_buffer_t;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      decoded_instr_t decoded_instr;
      logic [31:0]    wb_result;
   } mem_wb_buffer_t;

   localparam logic [31:0] RV_NOP_INSTR = `RV_NOP;

   function automatic decoded_instr_t create_nop_ctrl();
      decoded_instr_t c;
      c.mem_op        = MEM_NONE;
      c.wb_result_src = WB_SRC_NONE;
      return c;
   endfunction
endpackage

module rv32_mem_stage
   import rv32_mem_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  exec_mem_buffer_t exec_mem_buff,
   output mem_wb_buffer_t   mem_wb_buff,
   input  logic             stop,
   output logic             mem_busy,
   output logic [31:0]      wb_bypass,
   output logic             misaligned_exc,
   rv32_mem_stage_if.master dbus
);
   typedef enum logic [1:0] {IDLE, WAIT_RVALID, HOLD} state_t;

   state_t         state, state_nxt;
   logic [31:0]    rdata_q, rdata_nxt;
   mem_wb_buffer_t wb_nxt, wb_pass;
   logic           exc_nxt;
   mem_op_t        op;
   logic [1:0]     off;
   logic           is_load, is_store, is_mem, misaligned;

   function automatic logic [31:0] load_fmt(mem_op_t lop, logic [1:0] loff, logic [31:0] rd);
      logic [15:0] sh;
      sh = 16'(rd >> {loff, 3'b000});
      case (lop)
         MEM_LB:  return {{24{sh[7]}}, sh[7:0]};
         MEM_LBU: return {24'h0, sh[7:0]};
         MEM_LH:  return {{16{sh[15]}}, sh[15:0]};
         MEM_LHU: return {16'h0, sh[15:0]};
         default: return rd;
      endcase
   endfunction

   always_comb begin
      op         = exec_mem_buff.decoded_instr.mem_op;
      off        = exec_mem_buff.mem_addr[1:0];
      is_load    = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
      is_store   = op inside {MEM_SB, MEM_SH, MEM_SW};
      is_mem     = is_load | is_store;
      misaligned = ((op inside {MEM_LH, MEM_LHU, MEM_SH}) && off[0]) ||
                   ((op inside {MEM_LW, MEM_SW}) && (off != 2'b00));
   end

   // Bus fields follow exec_mem_buff, which the front end holds stable while mem_busy is high.
   always_comb begin
      dbus.data_we    = is_store;
      dbus.data_addr  = {exec_mem_buff.mem_addr[31:2], 2'b00};
      dbus.data_wdata = exec_mem_buff.wb_result;
      dbus.data_be    = 4'b1111;
      case (op)
         MEM_SB, MEM_LB, MEM_LBU: begin
            dbus.data_be    = 4'b0001 << off;
            dbus.data_wdata = {4{exec_mem_buff.wb_result[7:0]}};
         end
         MEM_SH, MEM_LH, MEM_LHU: begin
            dbus.data_be    = 4'b0011 << off;
            dbus.data_wdata = {2{exec_mem_buff.wb_result[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      wb_pass.instr         = exec_mem_buff.instr;
      wb_pass.pc            = exec_mem_buff.pc;
      wb_pass.decoded_instr = exec_mem_buff.decoded_instr;
      wb_pass.wb_result     = exec_mem_buff.wb_result;
   end

   always_comb begin
      state_nxt     = state;
      rdata_nxt     = rdata_q;
      wb_nxt        = mem_wb_buff;
      exc_nxt       = 1'b0;
      mem_busy      = 1'b0;
      dbus.data_req = 1'b0;
      unique case (state)
         IDLE: begin
            if (!is_mem) begin
               if (!stop) wb_nxt = wb_pass;
            end else if (stop) begin
               mem_busy = 1'b1;
            end else if (misaligned) begin
               exc_nxt                     = 1'b1;
               wb_nxt.instr                = `RV_NOP;
               wb_nxt.pc                   = exec_mem_buff.pc;
               wb_nxt.decoded_instr        = create_nop_ctrl();
               wb_nxt.wb_result            = '0;
            end else begin
               dbus.data_req = 1'b1;
               mem_busy      = 1'b1;
               if (dbus.data_gnt) begin
                  if (is_store) begin
                     mem_busy                           = 1'b0;
                     wb_nxt                             = wb_pass;
                     wb_nxt.decoded_instr.wb_result_src = WB_SRC_NONE;
                     wb_nxt.wb_result                   = '0;
                  end else begin
                     state_nxt = WAIT_RVALID;
                  end
               end
            end
         end
         WAIT_RVALID: begin
            mem_busy = 1'b1;
            if (dbus.data_rvalid) begin
               if (!stop) begin
                  mem_busy         = 1'b0;
                  wb_nxt           = wb_pass;
                  wb_nxt.wb_result = load_fmt(op, off, dbus.data_rdata);
                  state_nxt        = IDLE;
               end else begin
                  rdata_nxt = dbus.data_rdata;
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            mem_busy = 1'b1;
            if (!stop) begin
               mem_busy         = 1'b0;
               wb_nxt           = wb_pass;
               wb_nxt.wb_result = load_fmt(op, off, rdata_q);
               state_nxt        = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state                     <= IDLE;
         rdata_q                   <= '0;
         misaligned_exc            <= 1'b0;
         mem_wb_buff.instr         <= `RV_NOP;
         mem_wb_buff.pc            <= '0;
         mem_wb_buff.decoded_instr <= create_nop_ctrl();
         mem_wb_buff.wb_result     <= '0;
      end else begin
         state          <= state_nxt;
         rdata_q        <= rdata_nxt;
         misaligned_exc <= exc_nxt;
         mem_wb_buff    <= wb_nxt;
      end
   end

   assign wb_bypass = mem_wb_buff.wb_result;

   // The bus never returns read data in the cycle it grants a request.
   a_no_gnt_rvalid: assert property (@(posedge clk) disable iff (!resetn)
      !(dbus.data_gnt && dbus.data_rvalid));
endmodule

// File: tb/tb_rv32_mem_stage.sv
// Directed bench for rv32_mem_stage: pass-through, stores, loads, stop/HOLD,
// misalignment and reset during an outstanding load.
module tb_rv32_mem_stage;
   import rv32_mem_pkg::*;

   logic             clk = 1'b0;
   logic             resetn;
   logic             stop;
   exec_mem_buffer_t exec_mem_buff;
   mem_wb_buffer_t   mem_wb_buff;
   logic             mem_busy;
   logic [31:0]      wb_bypass;
   logic             misaligned_exc;
   int unsigned      n_tests = 0;
   int unsigned      n_fail  = 0;

   rv32_mem_stage_if bus();

   rv32_mem_stage dut (
      .clk            (clk),
      .resetn         (resetn),
      .exec_mem_buff  (exec_mem_buff),
      .mem_wb_buff    (mem_wb_buff),
      .stop           (stop),
      .mem_busy       (mem_busy),
      .wb_bypass      (wb_bypass),
      .misaligned_exc (misaligned_exc),
      .dbus           (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic exec_mem_buffer_t mk(logic [31:0] instr, logic [31:0] pc, mem_op_t op,
                                           wb_src_t src, logic [31:0] addr, logic [31:0] res);
      exec_mem_buffer_t b;
      b.instr                       = instr;
      b.pc                          = pc;
      b.decoded_instr.mem_op        = op;
      b.decoded_instr.wb_result_src = src;
      b.mem_addr                    = addr;
      b.wb_result                   = res;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic do_load(input string tag, input mem_op_t op, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] exp);
      exec_mem_buff = mk(32'h0000_0003, 32'h0000_0200, op, WB_SRC_MEM, addr, 32'h0);
      bus.data_gnt  = 1'b1;
      mid();
      check({tag, "_req"}, {31'h0, bus.data_req}, 32'h1);
      check({tag, "_busy_issue"}, {31'h0, mem_busy}, 32'h1);
      tick();
      bus.data_gnt    = 1'b0;
      bus.data_rvalid = 1'b1;
      bus.data_rdata  = rd;
      mid();
      check({tag, "_busy_rvalid"}, {31'h0, mem_busy}, 32'h0);
      tick();
      check({tag, "_result"}, wb_bypass, exp);
      bus.data_rvalid = 1'b0;
      exec_mem_buff   = mk(RV_NOP_INSTR, 32'h0000_0204, MEM_NONE, WB_SRC_NONE, 32'h0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn          = 1'b0;
      stop            = 1'b0;
      exec_mem_buff   = mk(RV_NOP_INSTR, 32'h0, MEM_NONE, WB_SRC_NONE, 32'h0, 32'h0);
      bus.data_gnt    = 1'b0;
      bus.data_rvalid = 1'b0;
      bus.data_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_instr", mem_wb_buff.instr, 32'h0000_0013);
      check("rst_pc", mem_wb_buff.pc, 32'h0);
      check("rst_wb", wb_bypass, 32'h0);
      check("rst_busy", {31'h0, mem_busy}, 32'h0);
      check("rst_req", {31'h0, bus.data_req}, 32'h0);
      check("rst_exc", {31'h0, misaligned_exc}, 32'h0);
      resetn = 1'b1;
      tick();

      // ALU result passes through with one cycle latency
      exec_mem_buff = mk(32'h0050_0093, 32'h100, MEM_NONE, WB_SRC_ALU, 32'h0, 32'h5);
      mid();
      check("addi_req", {31'h0, bus.data_req}, 32'h0);
      check("addi_busy", {31'h0, mem_busy}, 32'h0);
      tick();
      check("addi_wb", wb_bypass, 32'h5);
      check("addi_pc", mem_wb_buff.pc, 32'h100);

      exec_mem_buff = mk(32'h0090_0093, 32'h104, MEM_NONE, WB_SRC_ALU, 32'h0, 32'h9);
      stop = 1'b1;
      tick();
      check("stop_hold", wb_bypass, 32'h5);
      stop = 1'b0;
      tick();
      check("stop_release", wb_bypass, 32'h9);

      // SB with grant delayed two cycles
      exec_mem_buff = mk(32'h0020_01a3, 32'h108, MEM_SB, WB_SRC_NONE, 32'h1003, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         bus.data_gnt = (i == 2);
         mid();
         check("sb_req", {31'h0, bus.data_req}, 32'h1);
         check("sb_we", {31'h0, bus.data_we}, 32'h1);
         check("sb_be", {28'h0, bus.data_be}, 32'h8);
         check("sb_wdata", bus.data_wdata, 32'h7878_7878);
         check("sb_addr", bus.data_addr, 32'h1000);
         check("sb_busy", {31'h0, mem_busy}, (i == 2) ? 32'h0 : 32'h1);
         tick();
         if (i < 2) check("sb_wb_held", wb_bypass, 32'h9);
      end
      check("sb_wb", wb_bypass, 32'h0);
      check("sb_pc", mem_wb_buff.pc, 32'h108);
      bus.data_gnt  = 1'b0;
      exec_mem_buff = mk(RV_NOP_INSTR, 32'h10c, MEM_NONE, WB_SRC_NONE, 32'h0, 32'h0);
      tick();

      // SH upper half, immediate grant
      exec_mem_buff = mk(32'h0020_1123, 32'h110, MEM_SH, WB_SRC_NONE, 32'h1002, 32'haabb_5678);
      bus.data_gnt  = 1'b1;
      mid();
      check("sh_be", {28'h0, bus.data_be}, 32'hc);
      check("sh_wdata", bus.data_wdata, 32'h5678_5678);
      check("sh_addr", bus.data_addr, 32'h1000);
      check("sh_busy", {31'h0, mem_busy}, 32'h0);
      tick();
      bus.data_gnt  = 1'b0;
      exec_mem_buff = mk(RV_NOP_INSTR, 32'h114, MEM_NONE, WB_SRC_NONE, 32'h0, 32'h0);
      tick();

      do_load("lb",  MEM_LB,  32'h2001, 32'h0000_8000, 32'hffff_ff80);
      do_load("lhu", MEM_LHU, 32'h2002, 32'h8001_0000, 32'h0000_8001);
      do_load("lh",  MEM_LH,  32'h2002, 32'h8001_0000, 32'hffff_8001);
      do_load("lbu", MEM_LBU, 32'h2003, 32'h8000_0000, 32'h0000_0080);
      do_load("lw",  MEM_LW,  32'h2004, 32'hdead_beef, 32'hdead_beef);

      // LW stalled by stop, then captured data held across stop
      exec_mem_buff = mk(32'h0000_0093, 32'h300, MEM_NONE, WB_SRC_ALU, 32'h0, 32'h55);
      tick();
      exec_mem_buff = mk(32'h0000_2083, 32'h304, MEM_LW, WB_SRC_MEM, 32'h3000, 32'h0);
      stop = 1'b1;
      mid();
      check("stop_no_req", {31'h0, bus.data_req}, 32'h0);
      check("stop_busy", {31'h0, mem_busy}, 32'h1);
      tick();
      stop         = 1'b0;
      bus.data_gnt = 1'b1;
      mid();
      check("hold_req", {31'h0, bus.data_req}, 32'h1);
      tick();
      bus.data_gnt    = 1'b0;
      bus.data_rvalid = 1'b1;
      bus.data_rdata  = 32'hcafe_f00d;
      stop            = 1'b1;
      mid();
      check("hold_busy_rv", {31'h0, mem_busy}, 32'h1);
      tick();
      bus.data_rvalid = 1'b0;
      bus.data_rdata  = 32'h1111_1111;
      mid();
      check("hold_busy1", {31'h0, mem_busy}, 32'h1);
      check("hold_noreq", {31'h0, bus.data_req}, 32'h0);
      tick();
      check("hold_wb1", wb_bypass, 32'h55);
      bus.data_rdata = 32'h2222_2222;
      tick();
      check("hold_wb2", wb_bypass, 32'h55);
      stop = 1'b0;
      mid();
      check("hold_release_busy", {31'h0, mem_busy}, 32'h0);
      tick();
      check("hold_result", wb_bypass, 32'hcafe_f00d);
      exec_mem_buff = mk(RV_NOP_INSTR, 32'h308, MEM_NONE, WB_SRC_NONE, 32'h0, 32'h0);
      tick();

      // Misaligned accesses become NOP bubbles with a one-cycle exception pulse
      for (int i = 0; i < 3; i++) begin
         mem_op_t     mop;
         logic [31:0] maddr;
         mop   = (i == 0) ? MEM_LW : ((i == 1) ? MEM_SH : MEM_LHU);
         maddr = (i == 0) ? 32'h3002 : ((i == 1) ? 32'h1001 : 32'h2003);
         exec_mem_buff = mk(32'h0000_2083, 32'h400 + 32'(i * 8), mop, WB_SRC_MEM, maddr, 32'h0);
         mid();
         check("mis_req", {31'h0, bus.data_req}, 32'h0);
         check("mis_busy", {31'h0, mem_busy}, 32'h0);
         tick();
         check("mis_exc", {31'h0, misaligned_exc}, 32'h1);
         check("mis_instr", mem_wb_buff.instr, 32'h0000_0013);
         check("mis_pc", mem_wb_buff.pc, 32'h400 + 32'(i * 8));
         exec_mem_buff = mk(32'h0000_0093, 32'h404 + 32'(i * 8), MEM_NONE, WB_SRC_ALU, 32'h0, 32'h77);
         tick();
         check("mis_exc_clear", {31'h0, misaligned_exc}, 32'h0);
         check("mis_next_wb", wb_bypass, 32'h77);
      end

      // Reset while waiting for read data; late rvalid must be ignored
      exec_mem_buff = mk(32'h0000_2083, 32'h500, MEM_LW, WB_SRC_MEM, 32'h4000, 32'h0);
      bus.data_gnt  = 1'b1;
      tick();
      bus.data_gnt = 1'b0;
      mid();
      check("wait_busy", {31'h0, mem_busy}, 32'h1);
      #2;
      resetn        = 1'b0;
      exec_mem_buff = mk(RV_NOP_INSTR, 32'h0, MEM_NONE, WB_SRC_NONE, 32'h0, 32'h0);
      #1;
      check("rst2_instr", mem_wb_buff.instr, 32'h0000_0013);
      check("rst2_wb", wb_bypass, 32'h0);
      check("rst2_pc", mem_wb_buff.pc, 32'h0);
      check("rst2_busy", {31'h0, mem_busy}, 32'h0);
      check("rst2_req", {31'h0, bus.data_req}, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      tick();
      exec_mem_buff   = mk(32'h0000_0093, 32'h600, MEM_NONE, WB_SRC_ALU, 32'h0, 32'h66);
      bus.data_rvalid = 1'b1;
      bus.data_rdata  = 32'hbadb_ad00;
      mid();
      check("late_rv_busy", {31'h0, mem_busy}, 32'h0);
      tick();
      check("late_rv_wb", wb_bypass, 32'h66);
      bus.data_rvalid = 1'b0;

      // Back in IDLE: a granted store completes in its grant cycle
      exec_mem_buff = mk(32'h0020_2023, 32'h604, MEM_SW, WB_SRC_NONE, 32'h5000, 32'h0bad_f00d);
      bus.data_gnt  = 1'b1;
      mid();
      check("post_rst_sw_be", {28'h0, bus.data_be}, 32'hf);
      check("post_rst_sw_wdata", bus.data_wdata, 32'h0bad_f00d);
      check("post_rst_sw_busy", {31'h0, mem_busy}, 32'h0);
      tick();
      bus.data_gnt  = 1'b0;
      exec_mem_buff = mk(RV_NOP_INSTR, 32'h608, MEM_NONE, WB_SRC_NONE, 32'h0, 32'h0);
      check("post_rst_sw_pc", mem_wb_buff.pc, 32'h604);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rv32_mem_stage.md
Name: rv32_mem_stage

Overview:
- Fourth pipeline stage. Consumes exec_mem_buff registered by the exec stage and issues load/store transactions on the data-memory bus.
- Formats load data and registers the mem_wb_buff result for the writeback stage. Provides wb_bypass back to exec.
- Drives mem_busy to stall the front of the pipeline while a memory transaction is outstanding.

Parameters:
- none (fixed RV32, 32-bit word-addressed data bus)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- exec_mem_buff  in  $bits(exec_mem_buffer_t)  instr, pc, decoded_instr (mem_op, wb_result_src), mem_addr, wb_result (store data for stores)
- mem_wb_buff  out  $bits(mem_wb_buffer_t)  instr, pc, decoded_instr, wb_result
- stop  in  1  writeback/hazard stall; hold mem_wb_buff
- mem_busy  out  1  stall request to fetch/decode/exec
- wb_bypass  out  32  equals mem_wb_buff.wb_result
- misaligned_exc  out  1  one-cycle pulse on a misaligned load/store
- data_req  out  1  bus request
- data_we  out  1  1 = store
- data_be  out  4  byte enables
- data_addr  out  32  word address {mem_addr[31:2],2'b00}
- data_wdata  out  32  store data, lane-replicated
- data_gnt  in  1  request accepted this cycle
- data_rvalid  in  1  read data valid (earliest: cycle after gnt)
- data_rdata  in  32  read data

Behaviour:
Reset (asynchronous, resetn=0):
- mem_wb_buff.instr = `RV_NOP; pc = 0; decoded_instr = create_nop_ctrl(); wb_result = 0.
- state = IDLE; rdata_q = 0; data_req = 0; mem_busy = 0; misaligned_exc = 0.
- A reset during a transaction abandons it. An rvalid arriving after reset is ignored.

FSM states: IDLE, WAIT_RVALID, HOLD.
- IDLE, non-memory op (mem_op = MEM_NONE): if !stop, mem_wb_buff <= pass-through with wb_result = exec_mem_buff.wb_result. Latency 1. mem_busy = 0.
- IDLE, memory op, aligned, !stop: data_req = 1 (combinational) and mem_busy = 1 until completion.
  - Store + gnt: write completes; mem_wb_buff updated that edge; mem_busy = 0 in the gnt cycle.
  - Load + gnt: go to WAIT_RVALID.
  - No gnt: keep data_req and all bus fields stable; stay in IDLE.
- IDLE, memory op with stop = 1: no request issued; mem_busy = 1.
- WAIT_RVALID: data_req = 0; mem_busy = 1.
  - rvalid and !stop: mem_wb_buff <= formatted load; go to IDLE; mem_busy = 0 in that cycle.
  - rvalid and stop: rdata_q <= data_rdata; go to HOLD.
- HOLD: mem_busy = 1. When !stop: mem_wb_buff <= formatted rdata_q; go to IDLE; mem_busy = 0 that cycle.

Alignment:
- Misaligned means LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
- On misalignment: no bus request; misaligned_exc pulses one cycle; mem_wb_buff <= NOP bubble (instr = `RV_NOP, decoded_instr = create_nop_ctrl(), pc kept); mem_busy = 0.

Store lanes:
- SB: wdata = {4{rs2[7:0]}}, be = 4'b0001 << addr[1:0].
- SH: wdata = {2{rs2[15:0]}}, be = 4'b0011 << addr[1:0].
- SW: wdata = rs2, be = 4'b1111.
- Stores write wb_result = 0 and are not register-writing.

Load formatting:
- sh = data_rdata >> (8 * addr[1:0]).
- LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
- LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
- LW: data_rdata.

Simultaneous events and stop:
- rvalid in the same cycle as gnt is illegal; an assertion flags it.
- stop never drops a captured load: the data is held in rdata_q (HOLD).
- Whenever mem_wb_buff is not written (stop, or a pending memory op), it holds its value.

Test Plan:
- ADDI result 0x5 arriving, stop = 0 -> next edge mem_wb_buff.wb_result = 0x5; data_req never asserted.
- SB rs2 = 0x12345678, addr 0x1003, gnt held low 2 cycles -> data_req high 3 cycles with stable be = 4'b1000, wdata = 0x78787878, addr 0x1000; mem_busy low only in the gnt cycle.
- LB addr 0x2001, rdata 0x0000_8000 one cycle after gnt -> mem_wb_buff.wb_result = 0xFFFF_FF80. LHU addr 0x2002, rdata 0x8001_0000 -> 0x0000_8001. Total latency 2 cycles.
- LW with stop high on the rvalid cycle and 2 more cycles -> state HOLD; on stop release wb_result = rdata captured earlier; later bus rdata changes have no effect.
- LW at addr 0x3002 -> no data_req; misaligned_exc high 1 cycle; mem_wb_buff.instr = `RV_NOP.
- resetn low while in WAIT_RVALID, then rvalid after release -> outputs at reset values; rvalid ignored; state IDLE.
